rec_play_ctrl: RTL and testbench
================================

Name: rec_play_ctrl

Overview:
Record/playback sequencer for the audio recorder. It sits directly upstream of the 17-bit sample address counter, driving that counter's count-enable and reset inputs and the sample memory's write/read strobes. It paces memory accesses at the audio sample rate and tracks how many samples were recorded. It then replays exactly that many samples.

Parameters:
DIV, 2268, clk cycles per sample period (100 MHz / 44.1 kHz); legal range >= 4
ADDR_W, 17, address counter width; memory depth = 2^ADDR_W
DATA_W, 16, audio sample width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rec_btn  in  1  record button, asynchronous, level
play_btn  in  1  play button, asynchronous, level
sample_in  in  DATA_W  audio sample from ADC path
mem_dout  in  DATA_W  memory read data, valid 1 clk after mem_re
cnt_en  out  1  address counter advance pulse; the counter increments on its rising edge
cnt_reset  out  1  address counter clear
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_din  out  DATA_W  memory write data
sample_out  out  DATA_W  playback sample to DAC path
sample_valid  out  1  one-cycle strobe, sample_out updated
recording  out  1  high in REC_* states
playing  out  1  high in PLAY_* states
full  out  1  last record hit memory end
rec_len  out  ADDR_W+1  samples held in memory

Behaviour:
- Reset values: state IDLE; all outputs 0 except cnt_reset = 1. cnt_reset deasserts on the first clk edge after reset release. rec_len = 0 and shadow count = 0.
- Reset mid-operation aborts immediately with no further strobes. Recorded length is lost (rec_len = 0).
- Buttons: 2-FF synchronizer, then rising-edge detect. Only edges act; held levels do nothing.
- Sample tick: tick counter 0..DIV-1. It is cleared on entry to REC_WAIT/PLAY_WAIT from IDLE. tick = (count == DIV-1).
- All outputs are registered. Every strobe (mem_we, mem_re, cnt_en, cnt_reset, sample_valid) is exactly 1 clk wide.
- Shadow count (ADDR_W+1 bits) mirrors the external counter: cleared with cnt_reset, +1 with each cnt_en.
- States: IDLE, REC_WAIT, REC_WRITE, REC_ADV, PLAY_WAIT, PLAY_READ, PLAY_CAP, PLAY_ADV.
- IDLE, rec edge: cnt_reset pulse, count = 0, full = 0, go to REC_WAIT.
- IDLE, play edge with rec_len != 0: cnt_reset pulse, count = 0, go to PLAY_WAIT.
- IDLE, play edge with rec_len = 0: ignored.
- IDLE, rec and play edges in the same cycle: record wins.
- REC_WAIT, on tick: mem_din <= sample_in, mem_we asserted next cycle, go to REC_WRITE.
- REC_WAIT, rec edge: rec_len <= count, go to IDLE. Play edges are ignored while recording.
- REC_WRITE:
  - If count == 2^ADDR_W - 1: rec_len <= 2^ADDR_W, full = 1, go to IDLE, no cnt_en. The address never wraps.
  - Otherwise: cnt_en pulse, count+1, go to REC_ADV.
- REC_ADV: go to REC_WAIT.
- Record timing: the write uses the pre-increment address; cnt_en rises one clk after mem_we.
- A rec edge arriving in REC_WRITE/REC_ADV is held pending and honoured in the next REC_WAIT cycle.
- PLAY_WAIT, on tick: mem_re pulse, go to PLAY_READ.
- PLAY_WAIT, play edge: go to IDLE. Rec edges are ignored while playing.
- PLAY_READ: go to PLAY_CAP.
- PLAY_CAP: sample_out <= mem_dout, sample_valid pulse.
  - If count + 1 == rec_len: go to IDLE.
  - Otherwise: cnt_en pulse, count+1, go to PLAY_ADV.
- PLAY_ADV: go to PLAY_WAIT.
- A play edge arriving in PLAY_READ/PLAY_CAP/PLAY_ADV is held pending and honoured in the next PLAY_WAIT cycle.
- rec_len and full are unchanged by playback. sample_out holds its value between strobes.

Test Plan:
- Reset, then idle 10 clk (DIV=8, ADDR_W=4) -> cnt_reset high during reset and low one clk after release; no other strobes.
- Record: rec edge, 3 ticks, rec edge -> 3 mem_we pulses 8 clk apart; mem_din equals sample_in at each tick; each cnt_en 1 clk after its mem_we; rec_len = 3; full = 0.
- Record to full: rec edge, 16 ticks -> 16 mem_we, 15 cnt_en, rec_len = 16, full = 1, auto-return to IDLE; counter model ends at 15.
- Playback after 3-sample record, mem model returns 0xA000+addr -> sample_valid 3 times with 0xA000, 0xA001, 0xA002; 2 cnt_en; back to IDLE.
- Play edge with rec_len = 0 -> no strobes, playing stays 0. Rec and play edges together -> recording = 1.
- Reset asserted while mem_we cycle pending in REC_WRITE -> no mem_we/cnt_en after assertion; rec_len = 0, state IDLE.

Source files
------------

// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer for the audio recorder.
//
// Drives the external sample address counter (cnt_en / cnt_reset) and the sample
// memory strobes (mem_we / mem_re), pacing accesses at one per DIV clocks. A record
// pass stores samples until a second rec press or until memory is full; a play pass
// replays exactly rec_len samples.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   rec_btn, play_btn   asynchronous level buttons (synchronised, rising edge acts)
//   sample_in           ADC sample, latched into mem_din on each record tick
//   mem_dout            memory read data, valid one clk after mem_re
//   cnt_en, cnt_reset   address counter advance / clear pulses
//   mem_we, mem_re      memory write / read strobes
//   mem_din             memory write data
//   sample_out          last sample read back, qualified by sample_valid
//   recording, playing  high while in record / play states
//   full                last record pass reached the end of memory
//   rec_len             number of samples held in memory
module rec_play_ctrl #(
    parameter int unsigned DIV    = 2268,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_btn,
    input  logic              play_btn,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cnt_en,
    output logic              cnt_reset,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_din,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              recording,
    output logic              playing,
    output logic              full,
    output logic [ADDR_W:0]   rec_len
);

    localparam int unsigned     TW       = $clog2(DIV);
    localparam logic [TW-1:0]   TICK_MAX = TW'(DIV - 1);
    localparam logic [ADDR_W:0] LAST     = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StRecWait, StRecWrite, StRecAdv,
        StPlayWait, StPlayRead, StPlayCap, StPlayAdv
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        rec_sync_q, play_sync_q;
    logic              rec_prev_q, play_prev_q;
    logic              rec_pend_q, rec_pend_d, play_pend_q, play_pend_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d, sample_out_q, sample_out_d;
    logic              cnt_en_q, cnt_en_d, cnt_reset_q, cnt_reset_d;
    logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
    logic              sample_valid_q, sample_valid_d;
    logic              recording_q, recording_d, playing_q, playing_d;

    logic rec_edge, play_edge, rec_go, play_go, tick;

    assign rec_edge  = rec_sync_q[1] & ~rec_prev_q;
    assign play_edge = play_sync_q[1] & ~play_prev_q;
    // Edges seen during the write/read sub-states are deferred to the next WAIT cycle.
    assign rec_go    = rec_edge | rec_pend_q;
    assign play_go   = play_edge | play_pend_q;
    assign tick      = (tick_q == TICK_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            rec_sync_q     <= '0;
            play_sync_q    <= '0;
            rec_prev_q     <= 1'b0;
            play_prev_q    <= 1'b0;
            rec_pend_q     <= 1'b0;
            play_pend_q    <= 1'b0;
            tick_q         <= '0;
            count_q        <= '0;
            rec_len_q      <= '0;
            full_q         <= 1'b0;
            mem_din_q      <= '0;
            sample_out_q   <= '0;
            cnt_en_q       <= 1'b0;
            cnt_reset_q    <= 1'b1;
            mem_we_q       <= 1'b0;
            mem_re_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            recording_q    <= 1'b0;
            playing_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rec_sync_q     <= {rec_sync_q[0], rec_btn};
            play_sync_q    <= {play_sync_q[0], play_btn};
            rec_prev_q     <= rec_sync_q[1];
            play_prev_q    <= play_sync_q[1];
            rec_pend_q     <= rec_pend_d;
            play_pend_q    <= play_pend_d;
            tick_q         <= tick_d;
            count_q        <= count_d;
            rec_len_q      <= rec_len_d;
            full_q         <= full_d;
            mem_din_q      <= mem_din_d;
            sample_out_q   <= sample_out_d;
            cnt_en_q       <= cnt_en_d;
            cnt_reset_q    <= cnt_reset_d;
            mem_we_q       <= mem_we_d;
            mem_re_q       <= mem_re_d;
            sample_valid_q <= sample_valid_d;
            recording_q    <= recording_d;
            playing_q      <= playing_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rec_pend_d     = rec_pend_q;
        play_pend_d    = play_pend_q;
        count_d        = count_q;
        rec_len_d      = rec_len_q;
        full_d         = full_q;
        mem_din_d      = mem_din_q;
        sample_out_d   = sample_out_q;
        cnt_en_d       = 1'b0;
        cnt_reset_d    = 1'b0;
        mem_we_d       = 1'b0;
        mem_re_d       = 1'b0;
        sample_valid_d = 1'b0;

        // Free-running sample pacer, restarted from zero whenever a pass begins.
        if (state_q == StIdle || tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (rec_edge) begin
                    cnt_reset_d = 1'b1;
                    count_d     = '0;
                    full_d      = 1'b0;
                    state_d     = StRecWait;
                end else if (play_edge && rec_len_q != '0) begin
                    cnt_reset_d = 1'b1;
                    count_d     = '0;
                    state_d     = StPlayWait;
                end
            end
            StRecWait: begin
                if (rec_go) begin
                    rec_len_d = count_q;
                    state_d   = StIdle;
                end else if (tick) begin
                    mem_din_d = sample_in;
                    mem_we_d  = 1'b1;
                    state_d   = StRecWrite;
                end
            end
            StRecWrite: begin
                if (rec_edge) rec_pend_d = 1'b1;
                // Stop at the last address instead of letting the counter wrap.
                if (count_q == LAST) begin
                    rec_len_d = DEPTH;
                    full_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_en_d = 1'b1;
                    count_d  = count_q + 1'b1;
                    state_d  = StRecAdv;
                end
            end
            StRecAdv: begin
                if (rec_edge) rec_pend_d = 1'b1;
                state_d = StRecWait;
            end
            StPlayWait: begin
                if (play_go) begin
                    state_d = StIdle;
                end else if (tick) begin
                    mem_re_d = 1'b1;
                    state_d  = StPlayRead;
                end
            end
            StPlayRead: begin
                if (play_edge) play_pend_d = 1'b1;
                state_d = StPlayCap;
            end
            StPlayCap: begin
                if (play_edge) play_pend_d = 1'b1;
                sample_out_d   = mem_dout;
                sample_valid_d = 1'b1;
                if (count_q + 1'b1 == rec_len_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_en_d = 1'b1;
                    count_d  = count_q + 1'b1;
                    state_d  = StPlayAdv;
                end
            end
            StPlayAdv: begin
                if (play_edge) play_pend_d = 1'b1;
                state_d = StPlayWait;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            rec_pend_d  = 1'b0;
            play_pend_d = 1'b0;
        end

        recording_d = (state_d == StRecWait) || (state_d == StRecWrite) ||
                      (state_d == StRecAdv);
        playing_d   = (state_d == StPlayWait) || (state_d == StPlayRead) ||
                      (state_d == StPlayCap) || (state_d == StPlayAdv);
    end

    assign cnt_en       = cnt_en_q;
    assign cnt_reset    = cnt_reset_q;
    assign mem_we       = mem_we_q;
    assign mem_re       = mem_re_q;
    assign mem_din      = mem_din_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign recording    = recording_q;
    assign playing      = playing_q;
    assign full         = full_q;
    assign rec_len      = rec_len_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
module tb_rec_play_ctrl;

    localparam int DIV    = 8;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              rec_btn, play_btn;
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] mem_dout;
    logic              cnt_en, cnt_reset, mem_we, mem_re, sample_valid;
    logic              recording, playing, full;
    logic [DATA_W-1:0] mem_din, sample_out;
    logic [ADDR_W:0]   rec_len;

    int tests  = 0;
    int failed = 0;

    rec_play_ctrl #(
        .DIV    (DIV),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rec_btn      (rec_btn),
        .play_btn     (play_btn),
        .sample_in    (sample_in),
        .mem_dout     (mem_dout),
        .cnt_en       (cnt_en),
        .cnt_reset    (cnt_reset),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_din      (mem_din),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .recording    (recording),
        .playing      (playing),
        .full         (full),
        .rec_len      (rec_len)
    );

    always #5 clk = ~clk;

    // External address counter and memory read port models.
    logic [ADDR_W:0] ext_cnt = '0;
    always @(posedge clk) begin
        if (cnt_reset) ext_cnt <= '0;
        else if (cnt_en) ext_cnt <= ext_cnt + 1'b1;
        if (mem_re) mem_dout <= 16'hA000 + 16'(ext_cnt);
    end

    // Strobe logger, sampled on the falling edge.
    int                cyc = 0;
    int                we_cyc[$];
    int                en_cyc[$];
    int                we_addr[$];
    logic [DATA_W-1:0] din_log[$];
    logic [DATA_W-1:0] sv_log[$];
    int                n_re = 0;
    int                n_crst = 0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            we_cyc.push_back(cyc);
            we_addr.push_back(int'(ext_cnt));
            din_log.push_back(mem_din);
        end
        if (cnt_en) en_cyc.push_back(cyc);
        if (sample_valid) sv_log.push_back(sample_out);
        if (mem_re) n_re++;
        if (cnt_reset) n_crst++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        we_cyc.delete();
        en_cyc.delete();
        we_addr.delete();
        din_log.delete();
        sv_log.delete();
        n_re   = 0;
        n_crst = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic r, input logic p);
        rec_btn  = r;
        play_btn = p;
        repeat (3) step();
        rec_btn  = 1'b0;
        play_btn = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        clear_logs();
    endtask

    initial begin
        int budget;
        reset     = 1'b1;
        rec_btn   = 1'b0;
        play_btn  = 1'b0;
        sample_in = '0;

        // Reset state
        repeat (3) step();
        check("rst_cnt_reset", 32'(cnt_reset), 1);
        check("rst_strobes", {mem_we, mem_re, cnt_en, sample_valid, recording, playing, full}, 0);
        check("rst_rec_len", 32'(rec_len), 0);
        reset = 1'b0;
        step();
        check("rel_cnt_reset", 32'(cnt_reset), 0);
        clear_logs();
        repeat (10) step();
        check("idle_we", we_cyc.size(), 0);
        check("idle_en", en_cyc.size(), 0);
        check("idle_re_sv", n_re + sv_log.size() + n_crst, 0);

        // Record three samples then stop
        sample_in = 16'h1230;
        press(1'b1, 1'b0);
        check("rec_active", 32'(recording), 1);
        check("rec_crst", n_crst, 1);
        for (int k = 0; k < 3; k++) begin
            budget = 0;
            while (!mem_we && budget < 20) begin step(); budget++; end
            check($sformatf("rec_we%0d", k), 32'(mem_we), 1);
            sample_in = 16'h1231 + 16'(k);
            step();
        end
        press(1'b1, 1'b0);
        repeat (2) step();
        check("rec3_we_n", we_cyc.size(), 3);
        check("rec3_en_n", en_cyc.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rec3_din%0d", k), 32'(din_log[k]), 32'h1230 + k);
            check($sformatf("rec3_addr%0d", k), we_addr[k], k);
            check($sformatf("rec3_en_lag%0d", k), en_cyc[k] - we_cyc[k], 1);
        end
        check("rec3_gap01", we_cyc[1] - we_cyc[0], DIV);
        check("rec3_gap12", we_cyc[2] - we_cyc[1], DIV);
        check("rec3_len", 32'(rec_len), 3);
        check("rec3_full", 32'(full), 0);
        check("rec3_idle", 32'(recording), 0);
        check("rec3_cnt", 32'(ext_cnt), 3);

        // Playback of the three samples
        clear_logs();
        press(1'b0, 1'b1);
        check("play_active", 32'(playing), 1);
        budget = 0;
        while (playing && budget < 60) begin step(); budget++; end
        check("play_done", 32'(playing), 0);
        step();
        check("play_sv_n", sv_log.size(), 3);
        for (int k = 0; k < 3; k++)
            check($sformatf("play_sv%0d", k), 32'(sv_log[k]), 32'hA000 + k);
        check("play_en_n", en_cyc.size(), 2);
        check("play_re_n", n_re, 3);
        check("play_we_n", we_cyc.size(), 0);
        check("play_len_kept", 32'(rec_len), 3);
        check("play_hold", 32'(sample_out), 32'hA002);

        // Play with nothing recorded is ignored; simultaneous edges start recording
        do_reset();
        press(1'b0, 1'b1);
        repeat (4) step();
        check("play_empty", 32'(playing), 0);
        check("play_empty_strb", n_re + n_crst + sv_log.size() + en_cyc.size(), 0);
        press(1'b1, 1'b1);
        check("both_rec", 32'(recording), 1);
        check("both_play", 32'(playing), 0);
        press(1'b1, 1'b0);
        check("both_stop", 32'(recording), 0);
        check("both_len", 32'(rec_len), 0);

        // Record until memory is full
        clear_logs();
        sample_in = 16'h0BEE;
        press(1'b1, 1'b0);
        budget = 0;
        while (recording && budget < 200) begin step(); budget++; end
        check("full_stop", 32'(recording), 0);
        step();
        check("full_we_n", we_cyc.size(), 16);
        check("full_en_n", en_cyc.size(), 15);
        check("full_len", 32'(rec_len), 16);
        check("full_flag", 32'(full), 1);
        check("full_cnt", 32'(ext_cnt), 15);

        // Reset in the middle of a write cycle
        do_reset();
        press(1'b1, 1'b0);
        budget = 0;
        while (!mem_we && budget < 20) begin step(); budget++; end
        check("abort_we_seen", 32'(mem_we), 1);
        reset = 1'b1;
        #1;
        clear_logs();
        repeat (4) step();
        reset = 1'b0;
        repeat (4) step();
        check("abort_we", we_cyc.size(), 0);
        check("abort_en", en_cyc.size(), 0);
        check("abort_len", 32'(rec_len), 0);
        check("abort_idle", {recording, playing}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
